// File: rtl/cacheline_adaptor_if.sv
// Bus bundle between the cache-side line port and the 64-bit burst memory port.
// The slave view belongs to the adaptor; the master view drives it from outside.
interface cacheline_adaptor_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LINE_W = 256;
  localparam int unsigned BEAT_W = 64;

  logic [ADDR_W-1:0] pmem_address;
  logic              pmem_read;
  logic              pmem_write;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [BEAT_W-1:0] mem_burst_o;
  logic [BEAT_W-1:0] mem_burst_i;
  logic              mem_resp;

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata, mem_burst_i, mem_resp,
    output pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_burst_o
  );

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata, mem_burst_i, mem_resp,
    input  pmem_rdata, pmem_resp, mem_address, mem_read, mem_write, mem_burst_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit line request into a four-beat 64-bit memory burst (read or write),
// pulsing pmem_resp for one cycle after the fourth accepted beat.
module cacheline_adaptor (
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
);
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned N_BEATS = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned OFFS_W  = 5;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);

  typedef enum logic [2:0] {
    IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE
  } state_t;

  state_t                          r_state, w_state_nxt;
  logic [CNT_W-1:0]                r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]               r_addr, w_addr_nxt;
  logic [N_BEATS-1:0][BEAT_W-1:0]  r_line, w_line_nxt;
  logic [N_BEATS-1:0][BEAT_W-1:0]  r_rdata, w_rdata_nxt;
  logic                            r_pmem_resp, w_pmem_resp_nxt;
  logic                            r_mem_read, w_mem_read_nxt;
  logic                            r_mem_write, w_mem_write_nxt;
  logic [BEAT_W-1:0]               r_mem_burst_o, w_mem_burst_o_nxt;

  // Next-state and next-output decode; outputs are precomputed so they leave registers.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_line_nxt  = r_line;
    w_rdata_nxt = r_rdata;

    case (r_state)
      IDLE: begin
        if (bus.pmem_write || bus.pmem_read) begin
          w_addr_nxt  = {bus.pmem_address[ADDR_W-1:OFFS_W], {OFFS_W{1'b0}}};
          w_line_nxt  = bus.pmem_wdata;
          w_cnt_nxt   = '0;
          w_state_nxt = bus.pmem_write ? WR_BURST : RD_BURST;
        end
      end
      RD_BURST: begin
        if (bus.mem_resp) begin
          w_rdata_nxt[r_cnt] = bus.mem_burst_i;
          w_cnt_nxt          = CNT_W'(r_cnt + 1'b1);
          if (r_cnt == LAST_BEAT) w_state_nxt = RD_DONE;
        end
      end
      WR_BURST: begin
        if (bus.mem_resp) begin
          w_cnt_nxt = CNT_W'(r_cnt + 1'b1);
          if (r_cnt == LAST_BEAT) w_state_nxt = WR_DONE;
        end
      end
      RD_DONE, WR_DONE: w_state_nxt = IDLE;
      default:          w_state_nxt = IDLE;
    endcase

    w_mem_read_nxt    = (w_state_nxt == RD_BURST);
    w_mem_write_nxt   = (w_state_nxt == WR_BURST);
    w_pmem_resp_nxt   = (w_state_nxt == RD_DONE) || (w_state_nxt == WR_DONE);
    w_mem_burst_o_nxt = (w_state_nxt == WR_BURST) ? w_line_nxt[w_cnt_nxt] : '0;
  end

  // State and output registers; reset wins over any request or beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_line        <= '0;
      r_rdata       <= '0;
      r_pmem_resp   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_burst_o <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_addr        <= w_addr_nxt;
      r_line        <= w_line_nxt;
      r_rdata       <= w_rdata_nxt;
      r_pmem_resp   <= w_pmem_resp_nxt;
      r_mem_read    <= w_mem_read_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_mem_burst_o <= w_mem_burst_o_nxt;
    end
  end

  assign bus.pmem_rdata  = r_rdata;
  assign bus.pmem_resp   = r_pmem_resp;
  assign bus.mem_address = r_addr;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_burst_o = r_mem_burst_o;
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Randomized self-checking bench for cacheline_adaptor: a transaction-level model
// predicts beat order, burst outputs, completion timing and the assembled line.
module tb_cacheline_adaptor;
  typedef logic [3:0][63:0] line_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  line_t last_rdata;

  cacheline_adaptor_if bus ();

  cacheline_adaptor dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic line_t rnd_line();
    line_t l;
    for (int i = 0; i < 4; i++) l[i] = rnd64();
    return l;
  endfunction

  // mode 0: back-to-back beats; 1: fixed gapped pattern 1,0,0,1,1,0,1; 2: random gaps
  function automatic bit resp_at(input int mode, input int cyc);
    int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    case (mode)
      0:       return 1'b1;
      1:       return (cyc < 7) ? pat[cyc][0] : 1'b1;
      default: return $urandom_range(0, 2) != 0;
    endcase
  endfunction

  // One line transaction. abort_after >= 0 pulses rst once that many beats are in.
  task automatic xfer(input bit wr, input bit rd, input logic [31:0] addr, input line_t wdata,
                      input line_t rbeats, input int mode, input int abort_after);
    line_t       exp_line;
    logic [31:0] exp_addr;
    int          beats;
    int          cyc;
    bit          r;
    exp_line = last_rdata;
    exp_addr = {addr[31:5], 5'b0};
    beats    = 0;
    cyc      = 0;
    bus.pmem_address = addr;
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_wdata   = wdata;
    bus.mem_resp     = 1'b0;
    tick();
    while (beats < 4) begin
      if (cyc >= 40) begin
        check("burst_timeout", 256'(cyc), 256'(0));
        break;
      end
      check("mem_read",  256'(bus.mem_read),  256'(!wr));
      check("mem_write", 256'(bus.mem_write), 256'(wr));
      check("mem_addr",  256'(bus.mem_address), 256'(exp_addr));
      check("burst_o",   256'(bus.mem_burst_o), wr ? 256'(wdata[beats]) : 256'(0));
      check("resp_early", 256'(bus.pmem_resp), 256'(0));
      if (wr) check("rdata_hold", bus.pmem_rdata, last_rdata);
      if (beats == abort_after) begin
        rst          = 1'b1;
        bus.mem_resp = 1'b1;
        tick();
        rst            = 1'b0;
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.mem_resp   = 1'b0;
        last_rdata     = '0;
        check("abort_mem_read",  256'(bus.mem_read),  256'(0));
        check("abort_mem_write", 256'(bus.mem_write), 256'(0));
        check("abort_resp",      256'(bus.pmem_resp), 256'(0));
        check("abort_rdata",     bus.pmem_rdata, 256'(0));
        check("abort_addr",      256'(bus.mem_address), 256'(0));
        check("abort_burst_o",   256'(bus.mem_burst_o), 256'(0));
        tick();
        check("abort_no_resp",   256'(bus.pmem_resp), 256'(0));
        return;
      end
      r = resp_at(mode, cyc);
      bus.mem_resp    = r;
      bus.mem_burst_i = r ? rbeats[beats] : rnd64();
      tick();
      if (r) begin
        if (!wr) exp_line[beats] = rbeats[beats];
        beats++;
      end
      cyc++;
    end
    if (mode == 1) check("gap_cycles", 256'(cyc), 256'(7));
    // Stray strobe during the done cycle must be ignored.
    bus.mem_resp    = 1'($urandom_range(0, 1));
    bus.mem_burst_i = rnd64();
    if (!wr) last_rdata = exp_line;
    check("pmem_resp",      256'(bus.pmem_resp), 256'(1));
    check("done_mem_read",  256'(bus.mem_read),  256'(0));
    check("done_mem_write", 256'(bus.mem_write), 256'(0));
    check("done_burst_o",   256'(bus.mem_burst_o), 256'(0));
    check("done_addr",      256'(bus.mem_address), 256'(exp_addr));
    check("rdata",          bus.pmem_rdata, last_rdata);
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    tick();
    bus.mem_resp = 1'b0;
    check("resp_one_cycle", 256'(bus.pmem_resp), 256'(0));
    check("idle_mem_read",  256'(bus.mem_read),  256'(0));
    check("idle_mem_write", 256'(bus.mem_write), 256'(0));
    check("idle_rdata",     bus.pmem_rdata, last_rdata);
  endtask

  initial begin
    line_t       rb;
    line_t       wd;
    bit          wr;
    bit          rd;
    n_tests          = 0;
    n_fail           = 0;
    last_rdata       = '0;
    rst              = 1'b1;
    bus.pmem_address = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_wdata   = '0;
    bus.mem_burst_i  = '0;
    bus.mem_resp     = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_rdata",     bus.pmem_rdata, 256'(0));
    check("rst_resp",      256'(bus.pmem_resp), 256'(0));
    check("rst_mem_read",  256'(bus.mem_read), 256'(0));
    check("rst_mem_write", 256'(bus.mem_write), 256'(0));
    check("rst_burst_o",   256'(bus.mem_burst_o), 256'(0));
    check("rst_addr",      256'(bus.mem_address), 256'(0));

    // Directed read with known beats and unaligned address.
    rb[0] = 64'h1111_1111_1111_1111;
    rb[1] = 64'h2222_2222_2222_2222;
    rb[2] = 64'h3333_3333_3333_3333;
    rb[3] = 64'h4444_4444_4444_4444;
    xfer(1'b0, 1'b1, 32'h0000_1234, rnd_line(), rb, 0, -1);
    check("read_line_const", bus.pmem_rdata,
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Directed write.
    wd[0] = {16{4'hA}};
    wd[1] = {16{4'hB}};
    wd[2] = {16{4'hC}};
    wd[3] = {16{4'hD}};
    xfer(1'b1, 1'b0, 32'hCAFE_0047, wd, rnd_line(), 0, -1);

    // Gapped beats on read and write.
    xfer(1'b0, 1'b1, $urandom, rnd_line(), rnd_line(), 1, -1);
    xfer(1'b1, 1'b0, $urandom, rnd_line(), rnd_line(), 1, -1);

    // Read and write together: write wins.
    xfer(1'b1, 1'b1, $urandom, rnd_line(), rnd_line(), 0, -1);

    // Reset after two read beats, then a clean read.
    xfer(1'b0, 1'b1, 32'h0000_1234, rnd_line(), rnd_line(), 0, 2);
    xfer(1'b0, 1'b1, $urandom, rnd_line(), rnd_line(), 2, -1);

    // Spurious strobes while idle; the following write must still start at beat 0.
    bus.mem_resp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.mem_burst_i = rnd64();
      tick();
      check("spur_resp",      256'(bus.pmem_resp), 256'(0));
      check("spur_mem_read",  256'(bus.mem_read),  256'(0));
      check("spur_mem_write", 256'(bus.mem_write), 256'(0));
    end
    bus.mem_resp = 1'b0;
    xfer(1'b1, 1'b0, $urandom, rnd_line(), rnd_line(), 0, -1);

    // Randomized traffic, including occasional mid-burst aborts.
    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom_range(0, 1));
      rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      xfer(wr, rd, $urandom, rnd_line(), rnd_line(), 2,
           ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
